// File: rtl/crossing_turn_executor.sv
// Crossing manoeuvre sequencer: centres the axle over a line crossing, spins until the
// middle sensor reacquires the line, then hands the motors back to the line follower.
module crossing_turn_executor #(
    parameter int unsigned FRAME_COUNT     = 2_000_000,
    parameter int unsigned CLEAR_FRAMES    = 6,
    parameter int unsigned TURN_MIN_FRAMES = 10,
    parameter int unsigned TURN_MAX_FRAMES = 80
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       turn_crossing_start,
    input  logic [1:0] turn_cmd,
    input  logic       sensor_l,
    input  logic       sensor_m,
    input  logic       sensor_r,
    output logic       line_follower_start,
    output logic       motor_override,
    output logic       motor_l_reset,
    output logic       motor_l_direction,
    output logic       motor_r_reset,
    output logic       motor_r_direction,
    output logic       busy,
    output logic       turn_fault
);

    typedef enum logic [1:0] {IDLE, CLEAR, SPIN, DONE} state_t;

    state_t      state, next_state;
    logic [2:0]  sync_1, sync_2;
    logic [20:0] frame_cnt;
    logic [7:0]  state_frames;
    logic [1:0]  cmd;
    logic        seen_high, prev_low, pass_done, hold_start;
    logic        frame_tick, line_low, line_hit, final_hit, timeout, accept;
    logic        unused_sensors;

    assign frame_tick     = (state != IDLE) && (frame_cnt == 21'(FRAME_COUNT - 1));
    assign line_low       = ~sync_2[1];
    assign unused_sensors = sync_2[2] ^ sync_2[0];
    assign accept         = (state == IDLE) && turn_crossing_start && !hold_start;

    // A hit needs two consecutive low samples preceded by a high one in this arming window.
    assign line_hit  = (state == SPIN) && frame_tick
                     && (state_frames >= 8'(TURN_MIN_FRAMES))
                     && line_low && prev_low && seen_high;
    assign final_hit = line_hit && ((cmd != 2'b11) || pass_done);
    assign timeout   = (state == SPIN) && frame_tick
                     && (state_frames >= 8'(TURN_MAX_FRAMES - 1)) && !line_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = CLEAR;
                end
            end
            CLEAR: begin
                if (!turn_crossing_start) begin
                    next_state = IDLE;
                end else if (frame_tick && (state_frames == 8'(CLEAR_FRAMES - 1))) begin
                    next_state = (cmd == 2'b00) ? DONE : SPIN;
                end
            end
            SPIN: begin
                if (!turn_crossing_start) begin
                    next_state = IDLE;
                end else if (final_hit || timeout) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (!turn_crossing_start) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_1       <= '0;
            sync_2       <= '0;
            frame_cnt    <= '0;
            state_frames <= '0;
            cmd          <= '0;
            seen_high    <= 1'b0;
            prev_low     <= 1'b0;
            pass_done    <= 1'b0;
            hold_start   <= 1'b0;
            turn_fault   <= 1'b0;
        end else begin
            sync_1 <= {sensor_l, sensor_m, sensor_r};
            sync_2 <= sync_1;

            if ((state == IDLE) || (next_state == IDLE) || frame_tick) begin
                frame_cnt <= '0;
            end else begin
                frame_cnt <= frame_cnt + 21'd1;
            end

            if (next_state != state) begin
                state_frames <= '0;
            end else if (frame_tick && (state_frames != '1)) begin
                state_frames <= state_frames + 8'd1;
            end

            if (accept) begin
                cmd        <= turn_cmd;
                turn_fault <= 1'b0;
            end else if (timeout && (next_state == DONE)) begin
                turn_fault <= 1'b1;
            end

            if (state != SPIN) begin
                seen_high <= 1'b0;
                prev_low  <= 1'b0;
                pass_done <= 1'b0;
            end else if (frame_tick) begin
                prev_low <= line_low;
                if (line_hit) begin
                    pass_done <= 1'b1;
                    seen_high <= 1'b0;
                end else if (!line_low) begin
                    seen_high <= 1'b1;
                end
            end

            // A request still high after DONE must be seen low in IDLE before it counts again.
            if ((state == DONE) && (next_state == IDLE)) begin
                hold_start <= 1'b1;
            end else if ((state == IDLE) && !turn_crossing_start) begin
                hold_start <= 1'b0;
            end
        end
    end

    always_comb begin
        motor_l_reset       = 1'b1;
        motor_r_reset       = 1'b1;
        motor_l_direction   = 1'b0;
        motor_r_direction   = 1'b0;
        motor_override      = 1'b0;
        line_follower_start = 1'b0;
        busy                = (state != IDLE);
        case (state)
            CLEAR: begin
                motor_override    = 1'b1;
                motor_l_reset     = 1'b0;
                motor_r_reset     = 1'b0;
                motor_l_direction = 1'b1;
            end
            SPIN: begin
                motor_override    = 1'b1;
                motor_l_reset     = 1'b0;
                motor_r_reset     = 1'b0;
                motor_l_direction = (cmd != 2'b01);
                motor_r_direction = (cmd != 2'b01);
            end
            DONE: begin
                motor_override      = 1'b1;
                line_follower_start = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_crossing_turn_executor.sv
// Self-checking bench for crossing_turn_executor: per-cycle output checks against a
// frame-level model of the manoeuvre, with directed and randomized sensor patterns.
module tb_crossing_turn_executor;

    localparam int FC    = 100;
    localparam int CLR   = 3;
    localparam int TMIN  = 2;
    localparam int TMAX  = 8;
    localparam int CLEAR_END = CLR * FC + 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       turn_crossing_start = 1'b0;
    logic [1:0] turn_cmd = 2'b00;
    logic       sensor_l = 1'b1, sensor_m = 1'b1, sensor_r = 1'b1;
    logic       line_follower_start, motor_override, motor_l_reset, motor_l_direction;
    logic       motor_r_reset, motor_r_direction, busy, turn_fault;

    int total = 0;
    int bad   = 0;

    crossing_turn_executor #(
        .FRAME_COUNT(FC),
        .CLEAR_FRAMES(CLR),
        .TURN_MIN_FRAMES(TMIN),
        .TURN_MAX_FRAMES(TMAX)
    ) dut (
        .clk(clk),
        .reset(reset),
        .turn_crossing_start(turn_crossing_start),
        .turn_cmd(turn_cmd),
        .sensor_l(sensor_l),
        .sensor_m(sensor_m),
        .sensor_r(sensor_r),
        .line_follower_start(line_follower_start),
        .motor_override(motor_override),
        .motor_l_reset(motor_l_reset),
        .motor_l_direction(motor_l_direction),
        .motor_r_reset(motor_r_reset),
        .motor_r_direction(motor_r_direction),
        .busy(busy),
        .turn_fault(turn_fault)
    );

    always #5 clk = ~clk;

    // {line_follower_start, override, l_reset, l_dir, r_reset, r_dir, busy, fault}
    function automatic logic [7:0] out_vec();
        return {line_follower_start, motor_override, motor_l_reset, motor_l_direction,
                motor_r_reset, motor_r_direction, busy, turn_fault};
    endfunction

    function automatic logic [7:0] idle_vec(input logic f);
        return {7'b0010100, f};
    endfunction

    // Expected outputs c edges after the accepting edge (c=1 is the accepting edge).
    function automatic logic [7:0] exp_vec(input int c, input logic [1:0] cmd,
                                           input int done_c, input logic f);
        if (c >= done_c) return {7'b1110101, f};
        if (c < CLEAR_END) return 8'b0101_0010;
        if (cmd == 2'b01) return 8'b0100_0010;
        return 8'b0101_0110;
    endfunction

    // Frame-level turn model: pat[j] is the middle-sensor value at the j-th spin sample.
    function automatic void model_turn(input logic [1:0] cmd, input logic [8:0] pat,
                                       output int exit_j, output logic fault);
        int  last_hit, hits, need;
        logic hit;
        last_hit = -1;
        hits     = 0;
        need     = (cmd == 2'b11) ? 2 : 1;
        exit_j   = 8;
        fault    = 1'b1;
        for (int j = 0; j <= 8; j++) begin
            hit = 1'b0;
            if (j >= TMIN && j >= 1 && !pat[j] && !pat[j-1]) begin
                for (int i = last_hit + 1; i < j - 1; i++) begin
                    if (pat[i]) hit = 1'b1;
                end
            end
            if (hit) begin
                hits++;
                last_hit = j;
                if (hits == need) begin
                    exit_j = j;
                    fault  = 1'b0;
                    return;
                end
            end else if (j >= TMAX - 1) begin
                exit_j = j;
                fault  = 1'b1;
                return;
            end
        end
    endfunction

    task automatic run_turn(input string name, input logic [1:0] cmd,
                            input logic [8:0] pat, input int abort_c);
        int       exit_j, done_c, last_c, ci;
        logic     f;
        logic [7:0] got, exp;
        f = 1'b0;
        exit_j = 0;
        if (cmd == 2'b00) begin
            done_c = CLEAR_END;
        end else begin
            model_turn(cmd, pat, exit_j, f);
            done_c = CLEAR_END + FC * (exit_j + 1);
        end
        last_c = (abort_c > 0) ? abort_c : done_c + 3;
        turn_cmd = cmd;
        turn_crossing_start = 1'b1;
        for (int c = 1; c <= last_c; c++) begin
            @(posedge clk); #1;
            got = out_vec();
            exp = exp_vec(c, cmd, done_c, f);
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL %s cycle=%0d got=%b expected=%b", name, c, got, exp);
            end
            ci = c - CLEAR_END - FC / 2;
            if (ci < 0) sensor_m = 1'($urandom);
            else if ((ci % FC) == 0 && (ci / FC) <= 8) sensor_m = pat[ci / FC];
            turn_cmd = 2'($urandom);
            sensor_l = 1'($urandom);
            sensor_r = 1'($urandom);
        end
        turn_crossing_start = 1'b0;
        @(posedge clk); #1;
        exp = idle_vec((abort_c > 0) ? 1'b0 : f);
        total++;
        if (out_vec() !== exp) begin
            bad++;
            $display("FAIL %s_release got=%b expected=%b", name, out_vec(), exp);
        end
        if (abort_c == 0) begin
            turn_crossing_start = 1'b1;
            @(posedge clk); #1;
            total++;
            if (out_vec() !== exp) begin
                bad++;
                $display("FAIL %s_no_reaccept got=%b expected=%b", name, out_vec(), exp);
            end
            turn_crossing_start = 1'b0;
        end
        @(posedge clk); #1;
        total++;
        if (out_vec() !== exp) begin
            bad++;
            $display("FAIL %s_idle got=%b expected=%b", name, out_vec(), exp);
        end
        sensor_m = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        turn_crossing_start = 1'b1;
        turn_cmd = 2'($urandom);
        sensor_m = 1'($urandom);
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (out_vec() !== idle_vec(1'b0)) begin
            bad++;
            $display("FAIL reset_outputs got=%b expected=%b", out_vec(), idle_vec(1'b0));
        end
        total++;
        if (dut.frame_cnt !== 21'd0) begin
            bad++;
            $display("FAIL reset_frame_cnt got=%0d expected=0", dut.frame_cnt);
        end
        turn_crossing_start = 1'b0;
        reset = 1'b0;
        sensor_m = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_straight();
        run_turn("straight", 2'b00, 9'b1_1111_1111, 0);
    endtask

    task automatic test_left();
        run_turn("left", 2'b01, 9'b1_0000_1111, 0);
    endtask

    task automatic test_uturn();
        run_turn("uturn", 2'b11, 9'b1_0011_0011, 0);
    endtask

    task automatic test_early_line();
        run_turn("early_line", 2'b10, 9'b1_0000_1000, 0);
    endtask

    task automatic test_timeout();
        run_turn("timeout", 2'b10, 9'b1_1111_1111, 0);
        run_turn("fault_clear", 2'b00, 9'b1_1111_1111, 0);
    endtask

    task automatic test_abort();
        run_turn("abort", 2'b10, 9'b1_1111_1111, CLEAR_END + FC / 2);
    endtask

    task automatic test_reset_mid_clear();
        turn_cmd = 2'b01;
        turn_crossing_start = 1'b1;
        repeat (150) @(posedge clk);
        #1;
        total++;
        if (out_vec() !== 8'b0101_0010) begin
            bad++;
            $display("FAIL mid_clear got=%b expected=%b", out_vec(), 8'b0101_0010);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        total++;
        if (out_vec() !== idle_vec(1'b0)) begin
            bad++;
            $display("FAIL reset_mid_clear got=%b expected=%b", out_vec(), idle_vec(1'b0));
        end
        total++;
        if (dut.frame_cnt !== 21'd0) begin
            bad++;
            $display("FAIL reset_mid_clear_frame_cnt got=%0d expected=0", dut.frame_cnt);
        end
        turn_crossing_start = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [1:0] cmd;
        logic [8:0] pat;
        for (int n = 0; n < 5; n++) begin
            cmd = 2'($urandom_range(1, 3));
            pat = {1'b1, 8'($urandom)};
            run_turn("random", cmd, pat, 0);
        end
    endtask

    initial begin
        test_reset();
        test_straight();
        test_left();
        test_uturn();
        test_early_line();
        test_timeout();
        test_abort();
        test_reset_mid_clear();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
